// File: rtl/myintc_pkg.sv
// myintc_pkg: shared definitions for the myintc interrupt controller.
// Holds the register word offsets on the slave bus and the layout
// constants of the ACTIVE register (valid bit position, ID width).
package myintc_pkg;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_EDGE    = 2'd2;
  localparam logic [1:0] ADDR_ACTIVE  = 2'd3;

  localparam int ACTIVE_VALID_BIT = 31;
  localparam int ID_W             = 5;

endpackage

// File: rtl/myintc_prio.sv
// myintc_prio: combinational lowest-index priority encoder.
// Ports:
//   vec   in  [N_SRC-1:0] request vector, bit 0 = highest priority
//   id    out [ID_W-1:0]  index of the lowest set bit (0 when none)
//   valid out             at least one bit of vec is set
module myintc_prio
  import myintc_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] vec,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last to assign.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        id    = i[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/myintc.sv
// myintc: memory-mapped interrupt controller.
// Latches each request into PENDING (edge or level capture per source),
// masks it with MASK and drives one registered combined irq. ACTIVE
// gives the lowest enabled pending source for fast ISR dispatch.
// Ports:
//   clk          in      system clock
//   reset_n      in      asynchronous active-low reset
//   irq_in       in  [N] interrupt requests, synchronous to clk
//   s_cs_n       in      slave chip select, active low
//   s_address    in  [2] register word index (PENDING/MASK/EDGE/ACTIVE)
//   s_read       in      read strobe
//   s_readdata   out [32] registered read data
//   s_write      in      write strobe
//   s_writedata  in  [32] write data
//   irq          out     registered combined interrupt
module myintc
  import myintc_pkg::*;
#(
  parameter int          N_SRC      = 8,
  parameter logic [31:0] EDGE_RESET = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             s_cs_n,
  input  logic [1:0]       s_address,
  input  logic             s_read,
  output logic [31:0]      s_readdata,
  input  logic             s_write,
  input  logic [31:0]      s_writedata,
  output logic             irq
);

  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] edge_mode;
  logic [N_SRC-1:0] prev;

  logic             rd_en;
  logic             wr_en;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending_nxt;
  logic [ID_W-1:0]  act_id;
  logic             act_valid;
  logic [31:0]      reg_rdata;

  // Bits of the write bus beyond the implemented sources are ignored.
  logic unused_wdata;
  assign unused_wdata = ^s_writedata[31:N_SRC];

  assign rd_en = ~s_cs_n & s_read;
  assign wr_en = ~s_cs_n & s_write;

  assign clr  = (wr_en && s_address == ADDR_PENDING) ? s_writedata[N_SRC-1:0] : '0;
  assign rise = irq_in & ~prev;

  // Edge bits: a new rising edge wins over a same-cycle W1C.
  // Level bits: track the input directly, so W1C has no lasting effect.
  assign pending_nxt = (edge_mode & (rise | (pending & ~clr))) |
                       (~edge_mode & irq_in);

  myintc_prio #(.N_SRC(N_SRC)) u_prio (
    .vec   (pending & mask),
    .id    (act_id),
    .valid (act_valid)
  );

  always_comb begin
    reg_rdata = '0;
    case (s_address)
      ADDR_PENDING: reg_rdata[N_SRC-1:0] = pending;
      ADDR_MASK:    reg_rdata[N_SRC-1:0] = mask;
      ADDR_EDGE:    reg_rdata[N_SRC-1:0] = edge_mode;
      default: begin
        reg_rdata[ACTIVE_VALID_BIT] = act_valid;
        reg_rdata[ID_W-1:0]         = act_id;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      mask       <= '0;
      edge_mode  <= EDGE_RESET[N_SRC-1:0];
      prev       <= '0;
      s_readdata <= '0;
      irq        <= 1'b0;
    end else begin
      prev    <= irq_in;
      pending <= pending_nxt;
      irq     <= |(pending & mask);
      // Read mux sees pre-edge register values, so a same-cycle write
      // to the addressed register returns the old contents.
      if (rd_en)
        s_readdata <= reg_rdata;
      if (wr_en && s_address == ADDR_MASK)
        mask <= s_writedata[N_SRC-1:0];
      if (wr_en && s_address == ADDR_EDGE)
        edge_mode <= s_writedata[N_SRC-1:0];
    end
  end

endmodule
